// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
// Holds the FSM state encoding, the source-ID tag prefix and the default byte width.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

  localparam int UART_DEFAULT_DATA_WIDTH = 8;

  // Upper nibble of the tag byte that precedes each data byte in tagged builds.
  localparam logic [3:0] UART_TAG_PREFIX = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_TAG_ISSUE,
    ST_TAG_WAIT
  } uart_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester-side and transmitter-side handshake signals for the arbiter.
// master: arbiter view (drives ack/tx_data/tx_send). slave: requesters + transmitter view.
// Ports: req, req_data (NUM_REQ*DATA_WIDTH), ack, tx_data, tx_send, tx_busy.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = uart_pkg::UART_DEFAULT_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_send;
  logic                          tx_busy;

  modport master (
    input  req, req_data, tx_busy,
    output ack, tx_data, tx_send
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, tx_data, tx_send
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted req strictly after 'last', wrapping.
// Latency: zero (pure combinational). Backpressure: none; caller decides when to use grant.
// Ports: req, last (in); grant one-hot, idx binary (out). grant is all-zero when req is empty.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest match after 'last'
  // is written last and therefore wins, with no priority flag needed.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NUM_REQ;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NUM_REQ byte sources.
// Latency: req sampled in cycle n -> ack and tx_send in n+1; tx_busy seen in m -> tx_send low in m+1.
// Backpressure: holds tx_send until tx_busy rises, then waits for tx_busy low before re-arbitrating.
// Ports: clock, reset (sync, active-high), bus (uart_tx_arbiter_if.master), active (state != IDLE).
// Optional: define UART_ARB_TAG_EN to send a {4'hA,1'b0,src[2:0]} tag byte before each data byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = UART_DEFAULT_DATA_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  uart_tx_arbiter_if.master  bus,
  output logic               active
);

  localparam int IDX_W = $clog2(NUM_REQ);

  uart_state_t           state;
  logic [IDX_W-1:0]      last;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      win_idx;
  logic [DATA_WIDTH-1:0] win_data;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req   (bus.req),
    .last  (last),
    .grant (grant),
    .idx   (win_idx)
  );

  assign win_data = bus.req_data[win_idx*DATA_WIDTH +: DATA_WIDTH];
  assign active   = (state != ST_IDLE);

`ifdef UART_ARB_TAG_EN
  // Data byte parked here while the tag frame goes out first.
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] tag_byte;
  assign tag_byte = DATA_WIDTH'({UART_TAG_PREFIX, 1'b0, 3'(win_idx)});
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      last        <= IDX_W'(NUM_REQ - 1);
      bus.ack     <= '0;
      bus.tx_send <= 1'b0;
      bus.tx_data <= '0;
`ifdef UART_ARB_TAG_EN
      data_q      <= '0;
`endif
    end else begin
      bus.ack <= '0;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            bus.ack     <= grant;
            last        <= win_idx;
            bus.tx_send <= 1'b1;
`ifdef UART_ARB_TAG_EN
            data_q      <= win_data;
            bus.tx_data <= tag_byte;
            state       <= ST_TAG_ISSUE;
`else
            bus.tx_data <= win_data;
            state       <= ST_ISSUE;
`endif
          end
        end
        // Send is held indefinitely until the transmitter accepts; tx_data is
        // never touched here so the load cycle always sees a stable byte.
        ST_ISSUE: begin
          if (bus.tx_busy) begin
            bus.tx_send <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        // Going through IDLE (not straight back to ISSUE) guarantees send
        // cannot be re-raised on the cycle busy is first seen low.
        ST_WAIT: begin
          if (!bus.tx_busy) begin
            state <= ST_IDLE;
          end
        end
`ifdef UART_ARB_TAG_EN
        ST_TAG_ISSUE: begin
          if (bus.tx_busy) begin
            bus.tx_send <= 1'b0;
            state       <= ST_TAG_WAIT;
          end
        end
        ST_TAG_WAIT: begin
          if (!bus.tx_busy) begin
            bus.tx_data <= data_q;
            bus.tx_send <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
`endif
        default: begin
          bus.tx_send <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
